// File: rtl/layer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// layer_pkg : shared types for the password-cracker layers
// Rev 1.0
// ------------------------------------------------------------------
package layer_pkg;

    localparam int PASS_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        ACK   = 3'd2,
        CHECK = 3'd3,
        LOCK  = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/hs_watchdog.sv
`default_nettype none
// ------------------------------------------------------------------
// hs_watchdog : idle-cycle counter, expires on the TIMEOUT-th enabled cycle
// Rev 1.0
// ------------------------------------------------------------------
module hs_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of clear so the owner may derive clear from its next state.
    assign expire = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/layer1_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// layer1_rx : serial passcode receiver with handshake, compare and lockout
// Rev 1.0
// ------------------------------------------------------------------
module layer1_rx
    import layer_pkg::*;
#(
    parameter int WIDTH    = PASS_WIDTH,
    parameter int MAX_FAIL = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         rq8,
    input  logic                         Dout,
    input  logic [WIDTH-1:0]             secret,
    output logic                         goL1,
    output logic                         doneL1,
    output logic [WIDTH-1:0]             rx_word,
    output logic                         valid,
    output logic                         match,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
    output logic                         locked,
    output logic                         timeout_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    rx_state_t        state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [WIDTH-1:0] rx_word_q, rx_word_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [FW-1:0]    fail_q,    fail_d;
    logic             valid_q,   valid_d;
    logic             match_q,   match_d;
    logic             tmo_q,     tmo_d;

    logic             wd_enable;
    logic             wd_clear;
    logic             wd_expire;

    // Waiting for the very first bit is not a stall; only mid-frame idling is.
    assign wd_enable = (state_q == ACK) || ((state_q == READY) && (count_q != '0));
    assign wd_clear  = (state_d != state_q);

    hs_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rx_word_d = rx_word_q;
        count_d   = count_q;
        fail_d    = fail_q;
        match_d   = match_q;
        valid_d   = 1'b0;
        tmo_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    count_d = '0;
                    state_d = READY;
                end
            end
            READY: begin
                if (wd_expire) begin
                    tmo_d   = 1'b1;
                    shreg_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (rq8) begin
                    shreg_d = {shreg_q[WIDTH-2:0], Dout};
                    count_d = count_q + CW'(1);
                    state_d = ACK;
                end
            end
            ACK: begin
                if (wd_expire) begin
                    tmo_d   = 1'b1;
                    shreg_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (!rq8) begin
                    if (count_q == CW'(WIDTH)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = READY;
                    end
                end
            end
            CHECK: begin
                valid_d   = 1'b1;
                rx_word_d = shreg_q;
                match_d   = (shreg_q == secret);
                if (shreg_q == secret) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    fail_d = fail_q + FW'(1);
                    if (fail_d == FW'(MAX_FAIL)) begin
                        state_d = LOCK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK: begin
                state_d = LOCK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            rx_word_q <= '0;
            count_q   <= '0;
            fail_q    <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rx_word_q <= rx_word_d;
            count_q   <= count_d;
            fail_q    <= fail_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            tmo_q     <= tmo_d;
        end
    end

    assign goL1        = (state_q == READY);
    assign doneL1      = (state_q == READY) || (state_q == ACK);
    assign locked      = (state_q == LOCK);
    assign rx_word     = rx_word_q;
    assign valid       = valid_q;
    assign match       = match_q;
    assign fail_count  = fail_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_layer1_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_layer1_rx : table-driven frames with a scoreboard on the valid pulse
// Rev 1.0
// ------------------------------------------------------------------
module tb_layer1_rx;

    localparam int W  = 16;
    localparam int MF = 3;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          rq8;
    logic          Dout;
    logic [W-1:0]  secret;
    logic          goL1;
    logic          doneL1;
    logic [W-1:0]  rx_word;
    logic          valid;
    logic          match;
    logic [1:0]    fail_count;
    logic          locked;
    logic          timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] sec;
        logic [W-1:0] word;
        logic         exp_match;
        logic [1:0]   exp_fc;
        logic         exp_lock;
    } vec_t;

    typedef struct {
        logic [W-1:0] word;
        logic         match;
        logic [1:0]   fc;
        logic         lock;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    layer1_rx #(
        .WIDTH    (W),
        .MAX_FAIL (MF),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .rq8         (rq8),
        .Dout        (Dout),
        .secret      (secret),
        .goL1        (goL1),
        .doneL1      (doneL1),
        .rx_word     (rx_word),
        .valid       (valid),
        .match       (match),
        .fail_count  (fail_count),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_zero(input string name);
        check(name, 32'({goL1, doneL1, rx_word, valid, match, fail_count, locked, timeout_err}), 32'd0);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("rx_word",    32'(rx_word),    32'(e.word));
                check("match",      32'(match),      32'(e.match));
                check("fail_count", 32'(fail_count), 32'(e.fc));
                check("locked",     32'(locked),     32'(e.lock));
            end
        end
    end

    task automatic wait_go(output bit ok);
        int n = 0;
        while (!goL1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = goL1;
    endtask

    task automatic start_frame();
        bit ok;
        arm = 1'b1;
        @(negedge clk);
        wait_go(ok);
        arm = 1'b0;
        check("arm_to_ready", 32'(ok), 32'd1);
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int nbits, input int hold);
        bit ok;
        bit bad;
        int n;
        for (int i = 0; i < nbits; i++) begin
            wait_go(ok);
            check("go_wait", 32'(ok), 32'd1);
            Dout = word[W-1-i];
            rq8  = 1'b1;
            @(negedge clk);
            bad = 1'b0;
            for (int h = 0; h < hold; h++) begin
                if (goL1 || !doneL1) bad = 1'b1;
                @(negedge clk);
            end
            if (hold > 0) check("hold_in_ack", 32'(bad), 32'd0);
            n = 0;
            while (!(doneL1 && !goL1) && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("ack_wait", 32'(doneL1 && !goL1), 32'd1);
            rq8 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_frame(input logic [W-1:0] sec, input logic [W-1:0] word,
                             input logic em, input logic [1:0] efc, input logic el);
        exp_t e;
        secret  = sec;
        e.word  = word;
        e.match = em;
        e.fc    = efc;
        e.lock  = el;
        sb_q.push_back(e);
        start_frame();
        send_bits(word, W, 0);
        drain();
    endtask

    initial begin
        int  n;
        bit  seen;
        exp_t e;

        vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{16'hA5C3, 16'h0001, 1'b0, 2'd1, 1'b0};
        vecs[2] = '{16'hA5C3, 16'h0001, 1'b0, 2'd2, 1'b0};
        vecs[3] = '{16'hA5C3, 16'hA5C3, 1'b1, 2'd0, 1'b0};
        vecs[4] = '{16'hA5C3, 16'h0001, 1'b0, 2'd1, 1'b0};
        vecs[5] = '{16'hA5C3, 16'h0001, 1'b0, 2'd2, 1'b0};
        vecs[6] = '{16'hA5C3, 16'h0001, 1'b0, 2'd3, 1'b1};

        rst = 1'b1; arm = 1'b0; rq8 = 1'b0; Dout = 1'b0; secret = 16'hA5C3;
        repeat (3) @(negedge clk);
        check_zero("reset_asserted");
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_released");

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].sec, vecs[i].word, vecs[i].exp_match, vecs[i].exp_fc, vecs[i].exp_lock);
            check("idle_after_frame", 32'(goL1), 32'd0);
            check("locked_after_frame", 32'(locked), 32'(vecs[i].exp_lock));
        end

        // Locked: arm must be ignored entirely.
        arm  = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (goL1 || doneL1) seen = 1'b1;
        end
        arm = 1'b0;
        check("lock_ignores_arm", 32'(seen), 32'd0);
        check("lock_held", 32'(locked), 32'd1);
        check("lock_fc_sat", 32'(fail_count), 32'd3);

        rst = 1'b1;
        #1;
        check_zero("reset_from_lock");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_lock_reset");

        // Watchdog abort after a 5-bit stall.
        run_frame(16'hA5C3, 16'h0001, 1'b0, 2'd1, 1'b0);
        start_frame();
        send_bits(16'hA5C3, 5, 0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (timeout_err) seen = 1'b1;
        end
        check("timeout_latency", 32'(n), 32'(TO));
        check("timeout_idle", 32'({goL1, doneL1}), 32'd0);
        check("timeout_fc_kept", 32'(fail_count), 32'd1);
        check("timeout_word_kept", 32'(rx_word), 32'h0001);
        check("timeout_match_kept", 32'(match), 32'd0);
        @(negedge clk);
        check("timeout_pulse_width", 32'(timeout_err), 32'd0);
        run_frame(16'hA5C3, 16'hA5C3, 1'b1, 2'd0, 1'b0);

        // Reset in the middle of a frame clears the mismatch history.
        run_frame(16'hA5C3, 16'h0001, 1'b0, 2'd1, 1'b0);
        start_frame();
        send_bits(16'hA5C3, 9, 0);
        rst = 1'b1;
        #1;
        check_zero("reset_mid_frame");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_mid_reset");
        run_frame(16'h1234, 16'h1234, 1'b1, 2'd0, 1'b0);

        // One bit with rq8 held for 10 cycles must be latched once.
        secret  = 16'hA5C3;
        e.word  = 16'hA5C3;
        e.match = 1'b1;
        e.fc    = 2'd0;
        e.lock  = 1'b0;
        sb_q.push_back(e);
        start_frame();
        send_bits(16'hA5C3, 1, 10);
        send_bits(16'hA5C3 << 1, W - 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer1_rx.md
# layer1_rx

Layer 1 receive stage of the password cracker. It sits directly downstream of the Layer 2 serial sender. It runs a per-bit ready/request/acknowledge handshake with the sender, shifts in a WIDTH-bit passcode MSB-first, and compares the assembled word against the stored secret. It counts consecutive failed attempts and locks out permanently, until reset, after MAX_FAIL of them.

## Interface
- WIDTH, 16, passcode width in bits
- MAX_FAIL, 3, consecutive mismatches before lockout (≥1)
- TIMEOUT, 255, idle cycles tolerated mid-frame before the frame is aborted
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  start accepting a frame; level, sampled only in IDLE
- rq8  in  1  sender request: Dout valid while high
- Dout  in  1  serial data bit from sender
- secret  in  WIDTH  stored passcode; must be stable while armed
- goL1  out  1  receiver ready for next bit (latch window open)
- doneL1  out  1  receiver handshake-ready / bit acknowledged
- rx_word  out  WIDTH  last assembled word, held until next frame completes
- valid  out  1  one-cycle pulse: rx_word/match updated
- match  out  1  rx_word == secret for last frame, held
- fail_count  out  $clog2(MAX_FAIL+1)  consecutive mismatch count
- locked  out  1  lockout active
- timeout_err  out  1  one-cycle pulse: frame aborted by watchdog

## Operation
- Reset (async, any state): state=IDLE; shift register, bit count, watchdog=0. Every output is 0.
- IDLE: goL1=0, doneL1=0. When arm=1, clear bit count and go to READY.
- READY: doneL1=1, goL1=1. When rq8=1, shreg <= {shreg[WIDTH-2:0], Dout}, count++, go to ACK. The first bit lands in MSB after the full frame.
- ACK: doneL1=1, goL1=0. When rq8=0: if count==WIDTH go to CHECK, else go to READY. A new rq8 rise is never sampled in ACK.
- CHECK (one cycle):
  - Register rx_word<=shreg and match<=(shreg==secret), and pulse valid.
  - On match: fail_count<=0, go to IDLE.
  - On mismatch: fail_count++. If the new value equals MAX_FAIL, go to LOCK; else go to IDLE.
- LOCK: locked=1, goL1=0, doneL1=0. All inputs are ignored. Only rst exits.
- Watchdog counts cycles spent in READY with count>0, or in ACK.
  - It clears on every state transition.
  - On reaching TIMEOUT: pulse timeout_err, discard partial word, go to IDLE.
  - fail_count, rx_word and match are unchanged by a timeout.
- arm while not IDLE: ignored.
- arm held high: a new frame starts immediately after each CHECK.
- rq8 is same-clock-domain; no synchronizer.

## Timing
- Handshake per bit:
  - READY seen by sender → sender raises rq8 with Dout.
  - Edge where rq8=1 is sampled in READY: bit latched, goL1 falls next cycle.
  - Sender drops rq8 after seeing doneL1.
  - Edge where rq8=0 is sampled in ACK: return to READY.
  - Minimum 2 receiver cycles per bit.
- Frame completion: last rq8=0 sampled at edge E → CHECK during E..E+1. valid/match/rx_word are registered at E+1, and valid is high for exactly cycle E+1..E+2.
- All outputs are registered; there are no combinational input→output paths.
- fail_count saturates at MAX_FAIL; locked asserts in the cycle after the failing CHECK.
- Timeout abort occurs on the edge the watchdog reaches TIMEOUT. Exactly TIMEOUT cycles of inactivity are tolerated.
- Reset mid-frame: partial word is discarded; fail_count and lockout are cleared.

## Structure
- Shared package layer_pkg: rx state enum (IDLE, READY, ACK, CHECK, LOCK), default PASS_WIDTH=16. The Layer 2 sender also consumes PASS_WIDTH.
- One sub-module, hs_watchdog: parameterized TIMEOUT counter with clear/enable inputs and expire pulse output.
- Shift register, bit counter and compare live in layer1_rx.

## Test plan
- secret=16'hA5C3; arm; model sender drives A5C3 MSB-first → valid pulse once, rx_word=16'hA5C3, match=1, fail_count=0.
- secret=16'hA5C3; three frames of 16'h0001 → fail_count 1,2,3, locked=1 after third. A fourth arm produces no goL1, and goL1/doneL1 stay 0.
- Two mismatches then A5C3 → fail_count returns to 0, match=1, locked=0.
- Sender stalls after 5 bits for 255+ cycles → timeout_err pulse, state IDLE. Next full A5C3 frame → match=1, and fail_count is unaffected.
- Assert rst after 9 bits, then release → all outputs 0. A clean frame afterwards decodes correctly.
- rq8 held high for 10 cycles on one bit → exactly one bit is latched (count+1), no double sampling.
